// File: rtl/seq_s_packer.sv
`default_nettype none
// seq_s_packer: packs 2-bit nucleotide symbols into PE_ARRAY_SIZE-symbol chunks
// and buffers them in a two-entry FIFO for the PE array. Revision 1.0.

module seq_s_packer #(
  parameter int PE_ARRAY_SIZE     = 64,
  parameter int PE_ARRAY_SIZE_LOG = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [1:0]                   i_symbol,
  input  logic                         i_symbol_valid,
  input  logic                         i_symbol_last,
  output logic                         o_symbol_ready,
  input  logic                         i_request_s,
  output logic [PE_ARRAY_SIZE*2-1:0]   o_s,
  output logic [PE_ARRAY_SIZE_LOG-1:0] o_s_valid,
  output logic                         o_s_last,
  output logic                         o_s_empty,
  output logic                         o_busy,
  output logic                         o_underflow
);

  localparam int W = PE_ARRAY_SIZE * 2;
  localparam int L = PE_ARRAY_SIZE_LOG;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   pack_q, pack_d;
  logic [L-1:0]   cnt_q, cnt_d;
  logic [1:0]     occ_q, occ_d;
  logic [W-1:0]   hd_s_q, hd_s_d, tl_s_q, tl_s_d;
  logic [L-1:0]   hd_v_q, hd_v_d, tl_v_q, tl_v_d;
  logic           hd_l_q, hd_l_d, tl_l_q, tl_l_d;
  logic           und_q, und_d;

  logic           accept;
  logic           close;
  logic           pop;
  logic [W-1:0]   chunk_s;
  logic [L-1:0]   chunk_v;

  assign accept  = (state_q == PACK) && (occ_q < 2'd2) && i_symbol_valid;
  assign close   = accept && ((cnt_q == L'(PE_ARRAY_SIZE - 1)) || i_symbol_last);
  assign pop     = i_request_s && (occ_q != 2'd0);
  assign chunk_s = pack_q | ({{(W-2){1'b0}}, i_symbol} << {cnt_q, 1'b0});
  // A full chunk wraps to 0 here, which is the encoding for "all slots valid".
  assign chunk_v = cnt_q + L'(1);

  always_comb begin
    state_d = state_q;
    pack_d  = pack_q;
    cnt_d   = cnt_q;
    occ_d   = occ_q;
    hd_s_d  = hd_s_q;
    hd_v_d  = hd_v_q;
    hd_l_d  = hd_l_q;
    tl_s_d  = tl_s_q;
    tl_v_d  = tl_v_q;
    tl_l_d  = tl_l_q;
    und_d   = und_q;

    if (i_start) begin
      state_d = PACK;
      pack_d  = '0;
      cnt_d   = '0;
      occ_d   = 2'd0;
      hd_s_d  = '0;
      hd_v_d  = '0;
      hd_l_d  = 1'b0;
      tl_s_d  = '0;
      tl_v_d  = '0;
      tl_l_d  = 1'b0;
      und_d   = 1'b0;
    end else begin
      if (close) begin
        pack_d = '0;
        cnt_d  = '0;
      end else if (accept) begin
        pack_d = chunk_s;
        cnt_d  = cnt_q + L'(1);
      end

      if (i_request_s && (occ_q == 2'd0)) begin
        und_d = 1'b1;
      end

      // Pushes only happen below occupancy 2, so a pop at 2 never sees a push.
      if (pop) begin
        if (occ_q == 2'd2) begin
          hd_s_d = tl_s_q;
          hd_v_d = tl_v_q;
          hd_l_d = tl_l_q;
          tl_s_d = '0;
          tl_v_d = '0;
          tl_l_d = 1'b0;
          occ_d  = 2'd1;
        end else if (close) begin
          hd_s_d = chunk_s;
          hd_v_d = chunk_v;
          hd_l_d = i_symbol_last;
        end else begin
          hd_s_d = '0;
          hd_v_d = '0;
          hd_l_d = 1'b0;
          occ_d  = 2'd0;
        end
      end else if (close) begin
        if (occ_q == 2'd0) begin
          hd_s_d = chunk_s;
          hd_v_d = chunk_v;
          hd_l_d = i_symbol_last;
          occ_d  = 2'd1;
        end else begin
          tl_s_d = chunk_s;
          tl_v_d = chunk_v;
          tl_l_d = i_symbol_last;
          occ_d  = 2'd2;
        end
      end

      case (state_q)
        PACK: begin
          if (close && i_symbol_last) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (occ_d == 2'd0) begin
            state_d = IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pack_q  <= '0;
      cnt_q   <= '0;
      occ_q   <= 2'd0;
      hd_s_q  <= '0;
      hd_v_q  <= '0;
      hd_l_q  <= 1'b0;
      tl_s_q  <= '0;
      tl_v_q  <= '0;
      tl_l_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pack_q  <= pack_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      hd_s_q  <= hd_s_d;
      hd_v_q  <= hd_v_d;
      hd_l_q  <= hd_l_d;
      tl_s_q  <= tl_s_d;
      tl_v_q  <= tl_v_d;
      tl_l_q  <= tl_l_d;
      und_q   <= und_d;
    end
  end

  assign o_symbol_ready = (state_q == PACK) && (occ_q < 2'd2);
  assign o_s            = hd_s_q;
  assign o_s_valid      = hd_v_q;
  assign o_s_last       = hd_l_q;
  assign o_s_empty      = (occ_q == 2'd0);
  assign o_busy         = (state_q != IDLE);
  assign o_underflow    = und_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_s_packer.sv
`default_nettype none
// tb_seq_s_packer: directed and randomized checks of seq_s_packer (4-symbol chunks)
// against a queue-based chunk model.

module tb_seq_s_packer;

  localparam int N  = 4;
  localparam int LG = 2;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [1:0]    i_symbol;
  logic          i_symbol_valid;
  logic          i_symbol_last;
  logic          o_symbol_ready;
  logic          i_request_s;
  logic [2*N-1:0] o_s;
  logic [LG-1:0] o_s_valid;
  logic          o_s_last;
  logic          o_s_empty;
  logic          o_busy;
  logic          o_underflow;

  seq_s_packer #(.PE_ARRAY_SIZE(N), .PE_ARRAY_SIZE_LOG(LG)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_symbol       (i_symbol),
    .i_symbol_valid (i_symbol_valid),
    .i_symbol_last  (i_symbol_last),
    .o_symbol_ready (o_symbol_ready),
    .i_request_s    (i_request_s),
    .o_s            (o_s),
    .o_s_valid      (o_s_valid),
    .o_s_last       (o_s_last),
    .o_s_empty      (o_s_empty),
    .o_busy         (o_busy),
    .o_underflow    (o_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2*N-1:0] s;
    logic [LG-1:0]  v;
    logic           l;
  } chunk_t;

  localparam int M_IDLE = 0, M_PACK = 1, M_DRAIN = 2;

  chunk_t     q[$];
  logic [1:0] pk[$];
  int         mst;
  bit         und;
  bit         m_acc;
  int         n_vec;
  int         n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit     rdy;
    bit     closing;
    int     prev;
    chunk_t c;
    m_acc = 1'b0;
    if (!rst_n) begin
      mst = M_IDLE; pk.delete(); q.delete(); und = 1'b0;
      return;
    end
    if (i_start) begin
      mst = M_PACK; pk.delete(); q.delete(); und = 1'b0;
      return;
    end
    rdy     = (mst == M_PACK) && (q.size() < 2);
    m_acc   = i_symbol_valid && rdy;
    closing = 1'b0;
    c.s = '0; c.v = '0; c.l = 1'b0;
    if (m_acc) begin
      pk.push_back(i_symbol);
      if (pk.size() == N || i_symbol_last) begin
        closing = 1'b1;
        foreach (pk[k]) c.s[2*k +: 2] = pk[k];
        c.v = LG'(pk.size() % N);
        c.l = i_symbol_last;
        pk.delete();
      end
    end
    prev = mst;
    if (i_request_s) begin
      if (q.size() > 0) void'(q.pop_front());
      else und = 1'b1;
    end
    if (closing) q.push_back(c);
    if (closing && i_symbol_last) mst = M_DRAIN;
    else if (prev == M_DRAIN && q.size() == 0) mst = M_IDLE;
  endtask

  task automatic compare_all();
    chunk_t h;
    h.s = '0; h.v = '0; h.l = 1'b0;
    if (q.size() > 0) h = q[0];
    chk("o_s",            64'(o_s),            64'(h.s));
    chk("o_s_valid",      64'(o_s_valid),      64'(h.v));
    chk("o_s_last",       64'(o_s_last),       64'(h.l));
    chk("o_s_empty",      64'(o_s_empty),      64'(q.size() == 0));
    chk("o_busy",         64'(o_busy),         64'(mst != M_IDLE));
    chk("o_underflow",    64'(o_underflow),    64'(und));
    chk("o_symbol_ready", 64'(o_symbol_ready), 64'((mst == M_PACK) && (q.size() < 2)));
  endtask

  task automatic cycle(input bit st, input logic [1:0] sym, input bit sv, input bit sl,
                       input bit rq, input bit rs);
    i_start = st; i_symbol = sym; i_symbol_valid = sv; i_symbol_last = sl;
    i_request_s = rq; rst_n = !rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Offers one symbol until accepted, with a bounded wait.
  task automatic send(input logic [1:0] sym, input bit sl, input bit rq);
    for (int t = 0; t < 20; t++) begin
      cycle(1'b0, sym, 1'b1, sl, rq, 1'b0);
      if (m_acc) return;
    end
    n_vec++; n_err++;
    $display("FAIL send_timeout: got no accept expected accept at %0t", $time);
  endtask

  task automatic start_seq();
    cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int acc_cnt;
    n_vec = 0; n_err = 0;
    mst = M_IDLE; und = 1'b0; m_acc = 1'b0;
    i_start = 0; i_symbol = 0; i_symbol_valid = 0; i_symbol_last = 0; i_request_s = 0;
    rst_n = 1'b0;

    // Reset state
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_empty", 64'(o_s_empty), 64'd1);
    chk("rst_busy",  64'(o_busy),    64'd0);
    idle_cycle();

    // Full chunk closed by last
    start_seq();
    send(2'd0, 1'b0, 1'b0); send(2'd1, 1'b0, 1'b0); send(2'd2, 1'b0, 1'b0); send(2'd3, 1'b1, 1'b0);
    chk("full_s",     64'(o_s),       64'hE4);
    chk("full_valid", 64'(o_s_valid), 64'd0);
    chk("full_last",  64'(o_s_last),  64'd1);
    chk("full_empty", 64'(o_s_empty), 64'd0);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pop_empty", 64'(o_s_empty), 64'd1);
    chk("pop_busy",  64'(o_busy),    64'd0);

    // Short chunk: three symbols
    start_seq();
    send(2'd3, 1'b0, 1'b0); send(2'd3, 1'b0, 1'b0); send(2'd1, 1'b1, 1'b0);
    chk("short_s",     64'(o_s),       64'h1F);
    chk("short_valid", 64'(o_s_valid), 64'd3);
    chk("short_last",  64'(o_s_last),  64'd1);

    // Twelve symbols, no requests: FIFO fills after eight
    start_seq();
    acc_cnt = 0;
    for (int t = 0; t < 12; t++) begin
      cycle(1'b0, 2'(acc_cnt % 4), 1'b1, 1'b0, 1'b0, 1'b0);
      if (m_acc) acc_cnt++;
    end
    chk("fill_count", 64'(acc_cnt),        64'd8);
    chk("fill_ready", 64'(o_symbol_ready), 64'd0);
    chk("fill_last0", 64'(o_s_last),       64'd0);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pop1_last", 64'(o_s_last), 64'd0);
    chk("pop1_s",    64'(o_s),      64'hE4);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pop2_empty", 64'(o_s_empty), 64'd1);
    send(2'd0, 1'b0, 1'b0); send(2'd1, 1'b0, 1'b0); send(2'd2, 1'b0, 1'b0); send(2'd3, 1'b1, 1'b0);
    chk("chunk3_last", 64'(o_s_last), 64'd1);

    // Underflow: drain, then request on empty
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("uf_before", 64'(o_underflow), 64'd0);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("uf_set", 64'(o_underflow), 64'd1);
    idle_cycle(); idle_cycle();
    chk("uf_hold", 64'(o_underflow), 64'd1);
    start_seq();
    chk("uf_clear", 64'(o_underflow), 64'd0);

    // Same-edge push and pop at occupancy 1
    send(2'd0, 1'b0, 1'b0); send(2'd0, 1'b0, 1'b0); send(2'd0, 1'b0, 1'b0); send(2'd0, 1'b0, 1'b0);
    send(2'd1, 1'b0, 1'b0); send(2'd2, 1'b0, 1'b0); send(2'd3, 1'b0, 1'b0); send(2'd0, 1'b1, 1'b1);
    chk("pp_empty", 64'(o_s_empty), 64'd0);
    chk("pp_s",     64'(o_s),       64'h39);
    chk("pp_last",  64'(o_s_last),  64'd1);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pp_drained", 64'(o_s_empty), 64'd1);

    // Asynchronous reset mid-sequence
    start_seq();
    send(2'd1, 1'b0, 1'b0); send(2'd1, 1'b0, 1'b0);
    i_symbol_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  64'(o_busy),         64'd0);
    chk("arst_ready", 64'(o_symbol_ready), 64'd0);
    chk("arst_empty", 64'(o_s_empty),      64'd1);
    chk("arst_s",     64'(o_s),            64'd0);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycle(); idle_cycle();
    chk("post_rst_busy", 64'(o_busy), 64'd0);
    start_seq();
    send(2'd2, 1'b0, 1'b0); send(2'd2, 1'b0, 1'b0); send(2'd2, 1'b0, 1'b0); send(2'd2, 1'b1, 1'b0);
    chk("post_rst_s",    64'(o_s),      64'hAA);
    chk("post_rst_last", 64'(o_s_last), 64'd1);

    // Randomized traffic
    for (int t = 0; t < 3000; t++) begin
      cycle(($urandom_range(0, 59) == 0),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 399) == 0));
      if (mst == M_IDLE && $urandom_range(0, 3) == 0)
        cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
